pmem_responder: RTL
===================

Name: pmem_responder

Overview:
- Physical-memory-side responder for the cache/victim-cache pmem interface. The cache controller is the initiator: it raises pmem_read or pmem_write and holds it until pmem_resp.
- Services 128-bit line reads and writes from an internal line array after a fixed, parameterised latency.
- Used as the backing-memory model under the cache hierarchy and as the bench target for controller verification.

Parameters:
LATENCY, 4, cycles from first request cycle to the pmem_resp cycle; legal range 1..255
INDEX_BITS, 5, log2 of line count; the line index is pmem_address[4+INDEX_BITS-1:4]

Ports:
clk  in  1  clock; all logic on posedge
reset_n  in  1  synchronous active-low reset
pmem_read  in  1  read request; held by the initiator until pmem_resp
pmem_write  in  1  write request; held by the initiator until pmem_resp
pmem_address  in  16  byte address; bits [3:0] ignored
pmem_wdata  in  128  write line data
pmem_rdata  out  128  read line data; valid in the pmem_resp cycle of a read
pmem_resp  out  1  one-cycle completion pulse
busy  out  1  high in WAIT and RESP
err_both  out  1  sticky; set when read and write are accepted together
read_count  out  16  completed reads, saturating at 16'hFFFF
write_count  out  16  completed writes, saturating at 16'hFFFF

Behaviour:
- Reset (reset_n low at posedge):
  - state becomes IDLE; pmem_resp, busy and err_both become 0.
  - pmem_rdata, both counters and the latched request registers become 0.
  - All per-line valid bits are cleared; array data is left as-is.
  - Reset mid-operation aborts the request: no resp, no write commit.
- All outputs are registered. pmem_resp, pmem_rdata and busy come straight from flops; none depends combinationally on inputs.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If pmem_read or pmem_write is high, latch op, index and wdata.
  - If both are high, op = write and err_both is set.
  - Counter loads LATENCY-1. Go to WAIT, or directly to RESP when LATENCY=1.
- WAIT:
  - Counter decrements each cycle. When the counter is 1, go to RESP.
  - If the latched op's request signal goes low, the request is aborted: go to IDLE, no resp, no commit, counters unchanged.
  - Changes to pmem_address or pmem_wdata during WAIT are ignored (latched values are used).
- RESP:
  - pmem_resp=1 for exactly this cycle.
  - Read: pmem_rdata is the array line if its valid bit is set, else 128'h0. Loaded on the edge entering RESP, held until the next read's RESP.
  - Write: the array line and its valid bit are written on the edge leaving RESP. pmem_rdata is unchanged.
  - The matching counter increments on the edge leaving RESP, saturating.
  - Next state is always IDLE; requests in the RESP cycle are not sampled.
- Timing: with t0 = the IDLE cycle in which a request is first seen, pmem_resp is high in cycle t0+LATENCY.
  - A request held high in the IDLE cycle after RESP is a new back-to-back request, so the minimum request-to-request spacing is LATENCY+1 cycles.
- Read-after-write to the same line in the next request returns the new data; the write commit precedes the next IDLE sample.
- Address aliasing: bits above 4+INDEX_BITS-1 are ignored, so 16'h0040 and 16'h0240 map to the same line when INDEX_BITS=5.
- err_both clears only on reset.

Test Plan:
1. Reset, then read 16'h0010 held until resp (LATENCY=4) -> pmem_resp in cycle t0+4 only, pmem_rdata=0, read_count=1, busy high for t0+1..t0+4.
2. Write 16'h0020 with wdata=128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, then read 16'h0020 in the following IDLE cycle -> read resp returns that exact data, write_count=1, read_count=1, read resp 5 cycles after the write resp.
3. Assert read+write together at 16'h0030 -> treated as write, err_both=1 and stays 1 through later clean requests until reset_n=0.
4. Raise pmem_read, drop it at t0+2 -> no pmem_resp ever, read_count unchanged, state IDLE by t0+3. A new read at t0+5 completes normally at t0+9.
5. Write to 16'h0040, then read 16'h0240 -> aliased data returned. Then pulse reset_n low and read 16'h0040 -> returns 0 (valid bits cleared).
6. LATENCY=1 build: hold pmem_read continuously for 6 cycles -> pmem_resp in cycles t0+1, t0+3 and t0+5, i.e. every other cycle; read_count=3.

Source files
------------

// File: rtl/pmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : pmem_responder
// Brief   : Line-granular backing memory that answers cache pmem requests
//           after a fixed latency, with a registered one-cycle resp pulse.
// Rev     : 1.0  initial release
// ============================================================================
module pmem_responder #(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         busy,
  output logic         err_both,
  output logic [15:0]  read_count,
  output logic [15:0]  write_count
);

  localparam int         LINES    = 1 << INDEX_BITS;
  localparam logic [7:0] C_LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [127:0]          wdata_q, wdata_d;
  logic [127:0]          rdata_q, rdata_d;
  logic                  resp_q, resp_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [15:0]           rcnt_q, rcnt_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [127:0]          mem_q [LINES];

  logic [INDEX_BITS-1:0] w_addr_idx;
  logic [INDEX_BITS-1:0] w_rd_idx;
  logic                  w_unused_addr;

  assign w_addr_idx    = pmem_address[4+INDEX_BITS-1:4];
  assign w_unused_addr = ^pmem_address;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rcnt_d   = rcnt_q;
    wcnt_d   = wcnt_q;
    valid_d  = valid_q;
    w_rd_idx = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pmem_read || pmem_write) begin
          // A simultaneous read+write is serviced as a write and flagged.
          op_wr_d  = pmem_write;
          idx_d    = w_addr_idx;
          wdata_d  = pmem_wdata;
          cnt_d    = C_LAT_M1;
          w_rd_idx = w_addr_idx;
          if (pmem_read && pmem_write) begin
            err_d = 1'b1;
          end
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (op_wr_q ? !pmem_write : !pmem_read) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 8'd1) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        if (op_wr_q) begin
          valid_d[idx_q] = 1'b1;
          if (wcnt_q != 16'hFFFF) begin
            wcnt_d = wcnt_q + 16'd1;
          end
        end else begin
          if (rcnt_q != 16'hFFFF) begin
            rcnt_d = rcnt_q + 16'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Read data is captured on the edge entering RESP so it leaves a flop.
    if ((state_d == ST_RESP) && (state_q != ST_RESP) && !op_wr_d) begin
      rdata_d = valid_q[w_rd_idx] ? mem_q[w_rd_idx] : 128'h0;
    end

    resp_d = (state_d == ST_RESP);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 128'h0;
      rdata_q <= 128'h0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rcnt_q  <= 16'd0;
      wcnt_q  <= 16'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
      valid_q <= valid_d;
    end
  end

  // Line storage keeps its contents through reset; only valid bits clear.
  always_ff @(posedge clk) begin
    if (reset_n && (state_q == ST_RESP) && op_wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign pmem_rdata  = rdata_q;
  assign pmem_resp   = resp_q;
  assign busy        = busy_q;
  assign err_both    = err_q;
  assign read_count  = rcnt_q;
  assign write_count = wcnt_q;

endmodule
`default_nettype wire
